// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-enable divider, h/v position counters and
// registered sync/blanking/frame decodes aligned with the published position.
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = H_DISPLAY + H_FRONT + H_SYNC;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = V_DISPLAY + V_FRONT + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_MAX   = 10'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             frame_start_q, frame_start_d;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;

  // Half-open window test done in int so a window ending at 1024 cannot overflow.
  function automatic logic in_window(input logic [9:0] pos, input int lo, input int hi);
    return (int'(pos) >= lo) && (int'(pos) < hi);
  endfunction

  assign tick   = (div_q == DIV_MAX);
  assign h_wrap = tick && (h_q == H_MAX);
  assign v_wrap = h_wrap && (v_q == V_MAX);

  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      h_d = h_wrap ? '0 : h_q + 10'd1;
    end
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + 10'd1;
    end
    // Decode from next-state counters so the registered flags line up with pixel_x/y.
    hsync_d       = !in_window(h_d, HS_START, HS_END);
    vsync_d       = !in_window(v_d, VS_START, VS_END);
    video_on_d    = (int'(h_d) < H_DISPLAY) && (int'(v_d) < V_DISPLAY);
    frame_start_d = v_wrap;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Gated by reset so the pixel enable is quiet while held, even with CLK_DIV=1.
  assign p_tick      = tick & reset;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three configurations run side by side, a closed-form
// per-cycle scoreboard plus per-feature measurement tasks.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       fs;
  } obs_t;

  logic       d_hs, d_vs, d_von, d_pt, d_fs;
  logic [9:0] d_x, d_y;
  logic       m_hs, m_vs, m_von, m_pt, m_fs;
  logic [9:0] m_x, m_y;
  logic       s_hs, s_vs, s_von, s_pt, s_fs;
  logic [9:0] s_x, s_y;

  vga_sync_gen u_def (
    .clk(clk), .reset(reset), .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
    .p_tick(d_pt), .pixel_x(d_x), .pixel_y(d_y), .frame_start(d_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(3), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_mid (
    .clk(clk), .reset(reset), .hsync(m_hs), .vsync(m_vs), .video_on(m_von),
    .p_tick(m_pt), .pixel_x(m_x), .pixel_y(m_y), .frame_start(m_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_small (
    .clk(clk), .reset(reset), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
    .p_tick(s_pt), .pixel_x(s_x), .pixel_y(s_y), .frame_start(s_fs)
  );

  int checks = 0;
  int failures = 0;
  longint k = 0;
  obs_t q_d[$];
  obs_t q_m[$];
  obs_t q_s[$];
  obs_t a_d, a_m, a_s, e_d, e_m, e_s;
  localparam obs_t RST_OBS = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};

  // Expected outputs k clocks after reset release, from elapsed time alone.
  function automatic obs_t model(longint kk, int cd, int hd, int hf, int hsw, int hb,
                                 int vd, int vf, int vsw, int vb);
    obs_t r;
    longint ht, vt, ticks, x, y;
    ht    = hd + hf + hsw + hb;
    vt    = vd + vf + vsw + vb;
    ticks = kk / cd;
    x     = ticks % ht;
    y     = (ticks / ht) % vt;
    r.pt  = (kk % cd) == (cd - 1);
    r.x   = 10'(x);
    r.y   = 10'(y);
    r.hs  = !((x >= hd + hf) && (x < hd + hf + hsw));
    r.vs  = !((y >= vd + vf) && (y < vd + vf + vsw));
    r.von = (x < hd) && (y < vd);
    r.fs  = ((kk % cd) == 0) && (ticks > 0) && ((ticks % (ht * vt)) == 0);
    return r;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      k = 0;
    end else begin
      k = k + 1;
      q_d.push_back(model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33));
      q_m.push_back(model(k, 3, 16, 2, 4, 2, 12, 2, 2, 3));
      q_s.push_back(model(k, 1, 4, 1, 2, 1, 3, 1, 1, 1));
    end
  end

  always @(negedge clk) begin
    a_d = {d_pt, d_x, d_y, d_hs, d_vs, d_von, d_fs};
    a_m = {m_pt, m_x, m_y, m_hs, m_vs, m_von, m_fs};
    a_s = {s_pt, s_x, s_y, s_hs, s_vs, s_von, s_fs};
    if (!reset) begin
      e_d = RST_OBS; e_m = RST_OBS; e_s = RST_OBS;
    end else if (q_d.size() > 0 && q_m.size() > 0 && q_s.size() > 0) begin
      e_d = q_d.pop_front(); e_m = q_m.pop_front(); e_s = q_s.pop_front();
    end else begin
      e_d = a_d; e_m = a_m; e_s = a_s;
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL sb_queue_empty k=%0d", k);
    end
    checks = checks + 3;
    if (a_d !== e_d) begin
      failures = failures + 1;
      $display("FAIL sb_default k=%0d got=%h exp=%h", k, a_d, e_d);
    end
    if (a_m !== e_m) begin
      failures = failures + 1;
      $display("FAIL sb_mid k=%0d got=%h exp=%h", k, a_m, e_m);
    end
    if (a_s !== e_s) begin
      failures = failures + 1;
      $display("FAIL sb_small k=%0d got=%h exp=%h", k, a_s, e_s);
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if ({d_hs, d_vs, d_von, d_pt, d_x, d_y} !== {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0}) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", {d_hs, d_vs, d_von, d_pt, d_x, d_y},
               {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0});
    end
    reset = 1'b1;
    #1;
    checks++;
    if (d_pt !== 1'b0) begin
      failures++; $display("FAIL ptick_at_release got=%b exp=0", d_pt);
    end
    checks++;
    if (s_pt !== 1'b1) begin
      failures++; $display("FAIL small_ptick_release got=%b exp=1", s_pt);
    end
    @(negedge clk);
    checks++;
    if (d_von !== 1'b1 || d_x !== 10'd0 || d_y !== 10'd0) begin
      failures++; $display("FAIL first_clk_video_on got=%b x=%0d y=%0d exp=1,0,0", d_von, d_x, d_y);
    end
    checks++;
    if (d_pt !== 1'b1) begin
      failures++; $display("FAIL first_ptick_2nd_clk got=%b exp=1", d_pt);
    end
    @(negedge clk);
    checks++;
    if (d_x !== 10'd1) begin
      failures++; $display("FAIL x_after_first_tick got=%0d exp=1", d_x);
    end
  endtask

  task automatic test_horizontal();
    int c = 0, hs_low = 0, first_low = -1, last_low = -1, von_fall = -1, w1 = -1, w2 = -1;
    logic [9:0] px;
    logic pv;
    px = d_x; pv = d_von;
    for (int i = 0; i < 3400; i++) begin
      @(negedge clk);
      c++;
      if (d_y == 10'd1 && !d_hs) hs_low++;
      if (!d_hs && first_low < 0) first_low = int'(d_x);
      if (!d_hs && d_y == 10'd0) last_low = int'(d_x);
      if (pv && !d_von && von_fall < 0) von_fall = int'(d_x);
      if (px == 10'd799 && d_x == 10'd0) begin
        if (w1 < 0) w1 = c;
        else if (w2 < 0) w2 = c;
      end
      px = d_x; pv = d_von;
    end
    checks++;
    if (hs_low != 192) begin
      failures++; $display("FAIL hsync_low_clks got=%0d exp=192", hs_low);
    end
    checks++;
    if (first_low != 656 || last_low != 751) begin
      failures++; $display("FAIL hsync_window got=%0d..%0d exp=656..751", first_low, last_low);
    end
    checks++;
    if (von_fall != 640) begin
      failures++; $display("FAIL video_on_fall_x got=%0d exp=640", von_fall);
    end
    checks++;
    if (w2 < 0 || (w2 - w1) != 1600) begin
      failures++; $display("FAIL line_period got=%0d exp=1600", (w2 < 0) ? -1 : (w2 - w1));
    end
  endtask

  task automatic test_vertical();
    int c = 0, fs_n = 0, fs1 = -1, fs2 = -1, vs_low = 0, vmin = 1023, vmax = -1, bad_von = 0;
    for (int i = 0; i < 2800; i++) begin
      @(negedge clk);
      c++;
      if (m_fs) begin
        fs_n++;
        if (fs1 < 0) fs1 = c;
        else if (fs2 < 0) fs2 = c;
      end
      if (fs_n == 1 && !m_vs) vs_low++;
      if (!m_vs) begin
        if (int'(m_y) < vmin) vmin = int'(m_y);
        if (int'(m_y) > vmax) vmax = int'(m_y);
      end
      if (m_von && m_y >= 10'd12) bad_von++;
    end
    checks++;
    if (vs_low != 144) begin
      failures++; $display("FAIL vsync_low_clks got=%0d exp=144", vs_low);
    end
    checks++;
    if (vmin != 14 || vmax != 15) begin
      failures++; $display("FAIL vsync_lines got=%0d..%0d exp=14..15", vmin, vmax);
    end
    checks++;
    if (bad_von != 0) begin
      failures++; $display("FAIL video_on_in_vblank got=%0d exp=0", bad_von);
    end
    checks++;
    if (fs2 < 0 || (fs2 - fs1) != 1368) begin
      failures++; $display("FAIL frame_period got=%0d exp=1368", (fs2 < 0) ? -1 : (fs2 - fs1));
    end
  endtask

  task automatic test_wrap();
    int n = 0, fs_at = -1, fs_cnt = 0;
    while (!(m_x == 10'd23 && m_y == 10'd18 && m_pt) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1500) begin
      failures++; $display("FAIL wrap_reach_timeout got=%0d exp<1500", n);
    end else begin
      @(negedge clk);
      checks++;
      if (m_x !== 10'd0 || m_y !== 10'd0 || m_fs !== 1'b1) begin
        failures++; $display("FAIL wrap_corner got=x%0d y%0d fs%b exp=x0 y0 fs1", m_x, m_y, m_fs);
      end
      for (int j = 1; j <= 1368; j++) begin
        @(negedge clk);
        if (m_fs) begin
          fs_cnt++;
          if (fs_at < 0) fs_at = j;
        end
      end
      checks++;
      if (fs_at != 1368 || fs_cnt != 1) begin
        failures++; $display("FAIL frame_start_spacing got=%0d cnt=%0d exp=1368 cnt=1", fs_at, fs_cnt);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n = 0, stray = 0;
    while (!(m_x == 10'd20 && m_y == 10'd15) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1500 || m_hs !== 1'b0 || m_vs !== 1'b0) begin
      failures++; $display("FAIL midframe_syncs_low got=hs%b vs%b n=%0d exp=hs0 vs0", m_hs, m_vs, n);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({m_hs, m_vs, m_von, m_pt, m_x, m_y} !== {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0}) begin
      failures++; $display("FAIL async_reset got=%b exp=%b", {m_hs, m_vs, m_von, m_pt, m_x, m_y},
                           {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0});
    end
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (m_x !== 10'd0 || m_y !== 10'd0) begin
      failures++; $display("FAIL restart_origin got=x%0d y%0d exp=x0 y0", m_x, m_y);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!m_hs || !m_vs) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++; $display("FAIL stray_sync got=%0d exp=0", stray);
    end
  endtask

  task automatic test_small_config();
    int c = 0, pt_lo = 0, hs_bad = 0, vs_bad = 0, last = -1, nfs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      c++;
      if (!s_pt) pt_lo++;
      if (s_hs !== !(s_x == 10'd5 || s_x == 10'd6)) hs_bad++;
      if (s_vs !== (s_y != 10'd4)) vs_bad++;
      if (s_fs) begin
        if (last >= 0) begin
          checks++;
          if ((c - last) != 48) begin
            failures++; $display("FAIL small_frame_period got=%0d exp=48", c - last);
          end
        end
        last = c;
        nfs++;
      end
    end
    checks++;
    if (pt_lo != 0) begin
      failures++; $display("FAIL small_ptick_const got=%0d exp=0", pt_lo);
    end
    checks++;
    if (hs_bad != 0 || vs_bad != 0) begin
      failures++; $display("FAIL small_sync_decode got=hs%0d vs%0d exp=0,0", hs_bad, vs_bad);
    end
    checks++;
    if (nfs < 3) begin
      failures++; $display("FAIL small_frame_count got=%0d exp>=3", nfs);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_vertical();
    test_wrap();
    test_reset_midframe();
    test_small_config();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
